// File: rtl/rr_mux_reg_if.sv
// Handshake bundle for rr_mux_reg: N producer streams in, one tagged consumer stream out.
interface rr_mux_reg_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int CW = $clog2(N);

    logic            rr_en;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [CW-1:0]   out_ch;
    logic            out_ready;

    modport slave (
        input  rr_en, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    modport master (
        output rr_en, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_mux_reg.sv
// N-channel registered mux with round-robin / fixed-priority arbitration.
// One-word output register; each word is tagged with its source channel.
module rr_mux_reg #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_mux_reg_if.slave   mux_if
);
    localparam int CW = $clog2(N);

    logic [CW-1:0] ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [CW-1:0] out_ch_q, out_ch_d;

    logic          load_en;
    logic          xfer;
    logic          gnt_found;
    logic [CW-1:0] gnt_idx;
    logic [N-1:0]  req_hi;
    logic [N-1:0]  req_sel;
    logic [N-1:0]  ready;

    assign load_en = ~out_valid_q | mux_if.out_ready;

    // Round-robin: prefer requests at or above ptr, else fall back to the lowest.
    // With rr_en low req_hi is empty, which reduces to plain lowest-index priority.
    always_comb begin
        req_hi = '0;
        for (int k = 0; k < N; k++) begin
            req_hi[k] = mux_if.in_valid[k] & mux_if.rr_en & (k >= int'(ptr_q));
        end
        req_sel   = (req_hi != '0) ? req_hi : mux_if.in_valid;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_sel[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = CW'(k);
            end
        end
    end

    assign xfer = gnt_found & load_en;

    always_comb begin
        ready = '0;
        if (xfer) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (mux_if.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_if.in_data[int'(gnt_idx)*W +: W];
            out_ch_d    = gnt_idx;
            if (mux_if.rr_en) begin
                ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign mux_if.in_ready  = ready;
    assign mux_if.out_valid = out_valid_q;
    assign mux_if.out_data  = out_data_q;
    assign mux_if.out_ch    = out_ch_q;
endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: three instances (4x8, 2x1, 16x32) checked against an
// independent arbiter model and an expected-word queue per instance.
module tb_rr_mux_reg;
    localparam int NI = 3;

    typedef struct {
        int          ch;
        logic [31:0] d;
    } exp_t;

    logic clk;
    logic rst_n;

    rr_mux_reg_if #(.N(4),  .W(8))  if0 ();
    rr_mux_reg_if #(.N(2),  .W(1))  if1 ();
    rr_mux_reg_if #(.N(16), .W(32)) if2 ();

    rr_mux_reg #(.N(4),  .W(8))  u_dut0 (.clk(clk), .rst_n(rst_n), .mux_if(if0));
    rr_mux_reg #(.N(2),  .W(1))  u_dut1 (.clk(clk), .rst_n(rst_n), .mux_if(if1));
    rr_mux_reg #(.N(16), .W(32)) u_dut2 (.clk(clk), .rst_n(rst_n), .mux_if(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus state
    logic [15:0] vld  [NI];
    logic [31:0] dat  [NI][16];
    logic        rr   [NI];
    logic        ordy [NI];

    // reference model state
    int   m_ptr [NI];
    bit   m_ov  [NI];
    int   acc   [NI];
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_err = 0;

    function automatic int nof(int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 16;
    endfunction

    function automatic int wof(int k);
        return (k == 0) ? 8 : (k == 1) ? 1 : 32;
    endfunction

    function automatic void q_push(int k, exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(int k);
        return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    endfunction

    function automatic exp_t q_front(int k);
        exp_t e;
        e.ch = -1;
        e.d  = 32'hDEAD_BEEF;
        if (q_size(k) > 0) begin
            case (k)
                0:       e = q0[0];
                1:       e = q1[0];
                default: e = q2[0];
            endcase
        end
        return e;
    endfunction

    function automatic void q_pop(int k);
        if (q_size(k) > 0) begin
            case (k)
                0:       void'(q0.pop_front());
                1:       void'(q1.pop_front());
                default: void'(q2.pop_front());
            endcase
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_ptr[k] = 0;
            m_ov[k]  = 1'b0;
            acc[k]   = -1;
        end
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if0.rr_en = rr[0]; if0.out_ready = ordy[0]; if0.in_valid = vld[0][3:0];
        if1.rr_en = rr[1]; if1.out_ready = ordy[1]; if1.in_valid = vld[1][1:0];
        if2.rr_en = rr[2]; if2.out_ready = ordy[2]; if2.in_valid = vld[2][15:0];
        for (int c = 0; c < 4; c++)  if0.in_data[c*8 +: 8]   = dat[0][c][7:0];
        for (int c = 0; c < 2; c++)  if1.in_data[c*1 +: 1]   = dat[1][c][0:0];
        for (int c = 0; c < 16; c++) if2.in_data[c*32 +: 32] = dat[2][c];
    endtask

    task automatic read_dut(int k, output logic [31:0] r, output logic ov,
                            output logic [31:0] od, output int oc, output int p);
        case (k)
            0: begin
                r = 32'(if0.in_ready); ov = if0.out_valid; od = 32'(if0.out_data);
                oc = int'(if0.out_ch); p = int'(u_dut0.ptr_q);
            end
            1: begin
                r = 32'(if1.in_ready); ov = if1.out_valid; od = 32'(if1.out_data);
                oc = int'(if1.out_ch); p = int'(u_dut1.ptr_q);
            end
            default: begin
                r = 32'(if2.in_ready); ov = if2.out_valid; od = 32'(if2.out_data);
                oc = int'(if2.out_ch); p = int'(u_dut2.ptr_q);
            end
        endcase
    endtask

    // Compare one instance against the model, then advance the model over the coming edge.
    task automatic check(int k);
        int          n;
        int          w;
        int          g;
        int          c;
        bit          load;
        logic [31:0] wm;
        logic [31:0] er;
        logic [31:0] r;
        logic        ov;
        logic [31:0] od;
        int          oc;
        int          p;
        exp_t        e;
        n  = nof(k);
        w  = wof(k);
        wm = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        read_dut(k, r, ov, od, oc, p);
        load = !m_ov[k] || ordy[k];
        g = -1;
        if (rr[k]) begin
            for (int i = 0; i < n; i++) begin
                c = (m_ptr[k] + i) % n;
                if (g < 0 && vld[k][c]) g = c;
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                if (g < 0 && vld[k][i]) g = i;
            end
        end
        er = (g >= 0 && load) ? (32'd1 << g) : 32'd0;
        chk($sformatf("in_ready[%0d]", k), r, er);
        chk($sformatf("out_valid[%0d]", k), 32'(ov), 32'(m_ov[k]));
        chk($sformatf("ptr[%0d]", k), 32'(p), 32'(m_ptr[k]));
        if (m_ov[k]) begin
            e = q_front(k);
            chk($sformatf("out_data[%0d]", k), od, e.d);
            chk($sformatf("out_ch[%0d]", k), 32'(oc), 32'(e.ch));
        end
        acc[k] = -1;
        if (m_ov[k] && ordy[k]) begin
            q_pop(k);
            m_ov[k] = 1'b0;
        end
        if (g >= 0 && load) begin
            e.ch = g;
            e.d  = dat[k][g] & wm;
            q_push(k, e);
            m_ov[k] = 1'b1;
            acc[k]  = g;
            if (rr[k]) m_ptr[k] = (g + 1) % n;
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        for (int k = 0; k < NI; k++) check(k);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_chk(string tag);
        chk({tag, "_ov0"}, 32'(if0.out_valid), 32'd0);
        chk({tag, "_od0"}, 32'(if0.out_data),  32'd0);
        chk({tag, "_oc0"}, 32'(if0.out_ch),    32'd0);
        chk({tag, "_ptr0"}, 32'(u_dut0.ptr_q), 32'd0);
        chk({tag, "_ov1"}, 32'(if1.out_valid), 32'd0);
        chk({tag, "_ov2"}, 32'(if2.out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            vld[k] = '0; rr[k] = 1'b0; ordy[k] = 1'b0;
            for (int c = 0; c < 16; c++) dat[k][c] = '0;
        end
        model_reset();
        drive();
        @(negedge clk);
        cycle();
        reset_chk("reset");
        rst_n = 1'b1;

        // round-robin, all channels requesting
        dat[0][0] = 32'h10; dat[0][1] = 32'h21; dat[0][2] = 32'h32; dat[0][3] = 32'h43;
        rr[0] = 1'b1; ordy[0] = 1'b1; vld[0] = 16'hF;
        for (int i = 0; i < 7; i++) cycle();

        // fixed priority: channel 1 wins, ptr frozen
        rr[0] = 1'b0; vld[0] = 16'hE;
        for (int i = 0; i < 3; i++) cycle();
        chk("fixed_out_ch", 32'(if0.out_ch), 32'd1);

        // backpressure with 0x32 held
        rr[0] = 1'b1; vld[0] = 16'h4;
        cycle();
        ordy[0] = 1'b0; vld[0] = 16'hF;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_data", 32'(if0.out_data), 32'h32);
            chk("stall_ready", 32'(if0.in_ready), 32'd0);
        end
        ordy[0] = 1'b1;
        cycle();
        chk("unstall_next", 32'(if0.out_data), 32'h43);

        // pointer wrap with sparse requests
        vld[0] = 16'h4;
        cycle();
        chk("wrap_pre_ptr", 32'(u_dut0.ptr_q), 32'd3);
        vld[0] = 16'h5;
        cycle();
        chk("wrap_ch0", 32'(if0.out_ch), 32'd0);
        chk("wrap_ptr1", 32'(u_dut0.ptr_q), 32'd1);
        cycle();
        chk("wrap_ch2", 32'(if0.out_ch), 32'd2);
        chk("wrap_ptr3", 32'(u_dut0.ptr_q), 32'd3);

        // asynchronous reset mid-stream with 0xA5 held
        rr[0] = 1'b0; dat[0][0] = 32'hA5; vld[0] = 16'h1; ordy[0] = 1'b1;
        cycle();
        ordy[0] = 1'b0; vld[0] = 16'h0;
        drive();
        #1;
        chk("pre_rst_ov", 32'(if0.out_valid), 32'd1);
        chk("pre_rst_od", 32'(if0.out_data), 32'hA5);
        rst_n = 1'b0;
        #1;
        reset_chk("async_rst");
        model_reset();
        @(negedge clk);
        cycle();
        rst_n = 1'b1;

        // random sweep on the 2x1 and 16x32 instances
        rr[0] = 1'b0; vld[0] = '0; ordy[0] = 1'b1;
        for (int t = 0; t < 400; t++) begin
            for (int k = 1; k < NI; k++) begin
                rr[k]   = 1'($urandom_range(0, 1));
                ordy[k] = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < nof(k); c++) begin
                    if (!vld[k][c] && $urandom_range(0, 1) == 1) begin
                        vld[k][c] = 1'b1;
                        dat[k][c] = $urandom();
                    end
                end
            end
            cycle();
            for (int k = 1; k < NI; k++) begin
                if (acc[k] >= 0) vld[k][acc[k]] = 1'b0;
            end
        end
        for (int k = 1; k < NI; k++) begin
            vld[k] = '0;
            ordy[k] = 1'b1;
        end
        for (int i = 0; i < 3; i++) cycle();
        chk("drain_q1", 32'(q_size(1)), 32'd0);
        chk("drain_q2", 32'(q_size(2)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rr_mux_reg.md
# rr_mux_reg

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes and a selectable round-robin or fixed-priority arbiter. It is the successor to the combinational 4:1 mux: the select lines become an internal arbiter, and the output is a registered stage. The block merges several producer streams onto one consumer stream in the datapath, and each output word is tagged with its source channel.

## Interface
- N, 4: number of input channels; legal range 2..16.
- W, 8: data width per channel.
- CW, $clog2(N): width of the channel tag; derived, not overridden.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- rr_en  input  1  1 = round-robin arbitration, 0 = fixed priority (lowest index wins); sampled each cycle.
- in_valid  input  N  per-channel request; bit k belongs to channel k.
- in_data  input  N*W  channel k occupies bits [k*W +: W].
- in_ready  output  N  per-channel accept; at most one bit high per cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered word.
- out_ch  output  CW  index of the source channel of out_data.
- out_ready  input  1  consumer accepts the word.

## Operation
- Single cycle, one clock, and one reset.
- Internal state:
  - ptr[CW-1:0]: round-robin priority pointer.
  - Output register: out_valid, out_data, out_ch.
- load_en = ~out_valid | out_ready. The register can take a new word when it is empty, or when its current word leaves in the same cycle.
- Grant is combinational from in_valid, ptr and rr_en:
  - rr_en=1: the first channel with in_valid set, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
  - rr_en=0: the lowest-index channel with in_valid set; ptr is ignored.
- in_ready[g] = load_en & in_valid[g] for the granted channel g; all other bits are 0. in_ready never depends on out_valid through a combinational loop other than via load_en.
- An input transfer on channel g happens when in_valid[g] & in_ready[g]. At the next edge:
  - out_data is loaded from the channel g slice.
  - out_ch is set to g.
  - out_valid is set to 1.
- An output transfer happens when out_valid & out_ready. If no input transfer occurs in the same cycle, out_valid clears at the next edge. out_data and out_ch hold their last values.
- Stall (out_valid & ~out_ready): out_valid, out_data and out_ch hold stable and in_ready is all zero.
- ptr update, on an input transfer only:
  - With rr_en=1, ptr <= (g+1) mod N. If g = N-1, ptr wraps to 0.
  - With rr_en=0, ptr is unchanged.
  - No transfer leaves ptr unchanged.
- Switching rr_en mid-stream takes effect on the grant in the same cycle. It never corrupts the output register.
- Producers must hold in_valid and in_data until accepted. The block does not buffer more than one word.

## Timing
- Reset (rst_n low, asynchronous assert): out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready=0 immediately because the grant requires in_valid.
- Reset release is synchronised externally. The first grant is possible in the first cycle with rst_n high.
- Reset asserted mid-transfer discards the held word. No handshake completes in that cycle.
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 word per cycle while out_ready is held at 1. The pass-through case (out_valid & out_ready & new grant) loads back-to-back with no bubble.
- No valid input with out_ready=1: out_valid drops one cycle after the last output transfer.
- Fairness: with rr_en=1 and all N channels continuously valid and out_ready=1, each channel is granted exactly once in every N consecutive transfers.

## Test plan
- Reset: drive rst_n=0 mid-stream with out_valid=1 and out_data=0xA5. Required: out_valid, out_data, out_ch and ptr all read 0 immediately, with no clock edge needed.
- Round-robin (N=4, W=8, rr_en=1, out_ready=1): all in_valid=1111 with data 0x10, 0x21, 0x32, 0x43. Required: out_ch sequence 0,1,2,3,0,1… one per cycle, and out_data matching the source channel.
- Fixed priority: rr_en=0, in_valid=1110 held for 3 transfers. Required: channel 1 is granted every cycle and out_ch=1 each time. ptr holds its value from before rr_en went low.
- Backpressure: out_ready=0 for 5 cycles after out_valid with out_data=0x32. Required: out_data holds 0x32 and in_ready=0000 throughout. After out_ready rises, the next word appears 1 cycle later with no gap.
- Pointer wrap and sparse requests: ptr=3, in_valid=0101. Required: channel 0 is granted and ptr becomes 1. Next cycle, channel 2 is granted and ptr becomes 3.
- Parameter sweep: N=2, W=1 and N=16, W=32, each with random valid/ready. The scoreboard must see every accepted word exactly once, in order per channel, with the correct out_ch.
